// File: rtl/fsqrt_seq_if.sv
// Handshake bundle for the iterative square root unit.
//   in_valid/in_ready/rs1      : operand channel (master -> slave)
//   out_valid/out_ready/out    : result channel (slave -> master)
//   flag_nv/flag_nx            : IEEE exception flags, valid with out_valid
// master = issuing pipeline stage, slave = fsqrt_seq.
interface fsqrt_seq_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] rs1;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         flag_nv;
  logic         flag_nx;

  modport master (
    output in_valid, rs1, out_ready,
    input  in_ready, out_valid, out, flag_nv, flag_nx
  );

  modport slave (
    input  in_valid, rs1, out_ready,
    output in_ready, out_valid, out, flag_nv, flag_nx
  );
endinterface

// File: rtl/fsqrt_seq.sv
// Iterative IEEE 754 square root, round-to-nearest-even, restoring
// digit recurrence producing BPC root bits per CALC cycle.
// Ports:
//   clk     : clock, rising edge
//   resetn  : synchronous active-low reset
//   bus     : fsqrt_seq_if slave (operand in, result + nv/nx flags out)
// The interface instance must be built with W = 1+EXP_W+MAN_W.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | ready for an operand; specials resolved here straight to DONE
// S_NORM  | normalise subnormals, make exponent even, load recurrence
// S_CALC  | digit recurrence, counter runs N..1
// S_ROUND | round-to-nearest-even, pack result and flags
// S_DONE  | result valid, held until out_ready
module fsqrt_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int BPC   = 1
) (
  input logic        clk,
  input logic        resetn,
  fsqrt_seq_if.slave bus
);

  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int BIAS  = (1 << (EXP_W - 1)) - 1;
  localparam int R     = MAN_W + 2;
  localparam int N     = (R + BPC - 1) / BPC;
  localparam int QW    = N * BPC;         // root bits actually computed
  localparam int PAD   = QW - R;          // surplus low root bits, discarded
  localparam int RAD_W = 2 * QW;
  localparam int REM_W = QW + 2;
  localparam int EW    = EXP_W + 2;       // signed unbiased exponent width
  localparam int CNT_W = $clog2(N + 1);

  localparam logic [W-1:0]     QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(N);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_NORM,
    S_CALC,
    S_ROUND,
    S_DONE
  } state_t;

  state_t                 state_q,     state_d;
  logic [EXP_W-1:0]       opnd_exp_q,  opnd_exp_d;
  logic [MAN_W-1:0]       opnd_frac_q, opnd_frac_d;
  logic signed [EW-1:0]   exp_q,       exp_d;
  logic [RAD_W-1:0]       rad_q,       rad_d;
  logic [REM_W-1:0]       rem_q,       rem_d;
  logic [QW-1:0]          root_q,      root_d;
  logic [CNT_W-1:0]       cnt_q,       cnt_d;
  logic [W-1:0]           out_q,       out_d;
  logic                   nv_q,        nv_d;
  logic                   nx_q,        nx_d;

  // operand classification
  logic                   in_sgn;
  logic [EXP_W-1:0]       in_exp;
  logic [MAN_W-1:0]       in_frac;
  logic                   in_is_nan;
  logic                   in_is_zero;
  logic                   in_is_inf;

  assign in_sgn     = bus.rs1[W-1];
  assign in_exp     = bus.rs1[W-2 -: EXP_W];
  assign in_frac    = bus.rs1[MAN_W-1:0];
  assign in_is_nan  = (&in_exp) && (|in_frac);
  assign in_is_inf  = (&in_exp) && !(|in_frac);
  assign in_is_zero = !(|in_exp) && !(|in_frac);

  // rounding of the finished root
  logic [R-1:0]           q_r;
  logic                   sticky;
  logic                   rnd_up;
  logic [MAN_W-1:0]       frac_rnd;
  logic [EXP_W-1:0]       res_exp;
  logic                   unused_hidden;

  assign q_r      = root_q[QW-1 -: R];
  assign sticky   = |rem_q;
  assign rnd_up   = q_r[0] & (sticky | q_r[1]);
  // The root of a value in [1,4) never rounds up to 2.0, so no carry out.
  assign frac_rnd = q_r[R-2:1] + MAN_W'(rnd_up);
  // exp_q is always even here, so the arithmetic shift halves it exactly.
  assign res_exp  = EXP_W'((int'(exp_q) >>> 1) + BIAS);
  assign unused_hidden = q_r[R-1];

  generate
    if (PAD > 0) begin : g_pad
      logic unused_pad_bits;
      assign unused_pad_bits = ^root_q[PAD-1:0];
    end
  endgenerate

  // normalisation and recurrence temporaries
  int                     lead;
  int                     e_int;
  logic [MAN_W:0]         sig;
  logic [R-1:0]           x_rad;
  logic [REM_W-1:0]       rem_t;
  logic [REM_W-1:0]       rem_sh;
  logic [REM_W-1:0]       trial;
  logic [QW-1:0]          root_t;
  logic [RAD_W-1:0]       rad_t;

  always_comb begin
    state_d     = state_q;
    opnd_exp_d  = opnd_exp_q;
    opnd_frac_d = opnd_frac_q;
    exp_d       = exp_q;
    rad_d       = rad_q;
    rem_d       = rem_q;
    root_d      = root_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    nv_d        = nv_q;
    nx_d        = nx_q;
    lead        = 0;
    e_int       = 0;
    sig         = '0;
    x_rad       = '0;
    rem_t       = rem_q;
    rem_sh      = '0;
    trial       = '0;
    root_t      = root_q;
    rad_t       = rad_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          opnd_exp_d  = in_exp;
          opnd_frac_d = in_frac;
          if (in_is_nan) begin
            out_d   = QNAN;
            nv_d    = ~in_frac[MAN_W-1];   // quiet bit clear => signalling
            nx_d    = 1'b0;
            state_d = S_DONE;
          end else if (in_is_zero) begin
            out_d   = bus.rs1;
            nv_d    = 1'b0;
            nx_d    = 1'b0;
            state_d = S_DONE;
          end else if (in_sgn) begin
            out_d   = QNAN;
            nv_d    = 1'b1;
            nx_d    = 1'b0;
            state_d = S_DONE;
          end else if (in_is_inf) begin
            out_d   = bus.rs1;
            nv_d    = 1'b0;
            nx_d    = 1'b0;
            state_d = S_DONE;
          end else begin
            state_d = S_NORM;
          end
        end
      end

      S_NORM: begin
        if (opnd_exp_q == '0) begin
          // highest set fraction bit; later hits overwrite earlier ones
          for (int i = 0; i < MAN_W; i++) begin
            if (opnd_frac_q[i]) lead = i;
          end
          sig   = {1'b0, opnd_frac_q} << (MAN_W - lead);
          e_int = 1 - BIAS - (MAN_W - lead);
        end else begin
          sig   = {1'b1, opnd_frac_q};
          e_int = int'(opnd_exp_q) - BIAS;
        end
        if (e_int[0]) begin
          x_rad = {sig, 1'b0};
          e_int = e_int - 1;
        end else begin
          x_rad = {1'b0, sig};
        end
        exp_d   = EW'(e_int);
        rad_d   = {x_rad, {(RAD_W-R){1'b0}}};
        rem_d   = '0;
        root_d  = '0;
        cnt_d   = CNT_INIT;
        state_d = S_CALC;
      end

      S_CALC: begin
        // restoring step: bring down two radicand bits, try (4q+1)
        for (int s = 0; s < BPC; s++) begin
          rem_sh = {rem_t[REM_W-3:0], rad_t[RAD_W-1 -: 2]};
          trial  = {root_t, 2'b01};
          if (rem_sh >= trial) begin
            rem_t  = rem_sh - trial;
            root_t = {root_t[QW-2:0], 1'b1};
          end else begin
            rem_t  = rem_sh;
            root_t = {root_t[QW-2:0], 1'b0};
          end
          rad_t = {rad_t[RAD_W-3:0], 2'b00};
        end
        rem_d  = rem_t;
        root_d = root_t;
        rad_d  = rad_t;
        cnt_d  = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = S_ROUND;
      end

      S_ROUND: begin
        out_d   = {1'b0, res_exp, frac_rnd};
        nv_d    = 1'b0;
        nx_d    = q_r[0] | sticky;
        state_d = S_DONE;
      end

      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      opnd_exp_q  <= '0;
      opnd_frac_q <= '0;
      exp_q       <= '0;
      rad_q       <= '0;
      rem_q       <= '0;
      root_q      <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      nv_q        <= 1'b0;
      nx_q        <= 1'b0;
    end else begin
      opnd_exp_q  <= opnd_exp_d;
      opnd_frac_q <= opnd_frac_d;
      exp_q       <= exp_d;
      rad_q       <= rad_d;
      rem_q       <= rem_d;
      root_q      <= root_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      nv_q        <= nv_d;
      nx_q        <= nx_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE) && resetn;
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.out       = out_q;
  assign bus.flag_nv   = nv_q;
  assign bus.flag_nx   = nx_q;

endmodule

// File: tb/tb_fsqrt_seq.sv
module tb_fsqrt_seq;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  fsqrt_seq_if #(.W(32)) b1 ();
  fsqrt_seq_if #(.W(32)) b2 ();

  fsqrt_seq #(.EXP_W(8), .MAN_W(23), .BPC(1)) dut1 (
    .clk    (clk),
    .resetn (resetn),
    .bus    (b1)
  );

  fsqrt_seq #(.EXP_W(8), .MAN_W(23), .BPC(2)) dut2 (
    .clk    (clk),
    .resetn (resetn),
    .bus    (b2)
  );

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    assert (got === expv)
    else begin
      failures++;
      $error("FAIL %s got=%h expected=%h", tag, got, expv);
    end
  endtask

  task automatic drive(input int d, input logic v, input logic [31:0] x, input logic ordy);
    if (d == 0) begin
      b1.in_valid = v; b1.rs1 = x; b1.out_ready = ordy;
    end else begin
      b2.in_valid = v; b2.rs1 = x; b2.out_ready = ordy;
    end
  endtask

  function automatic logic [31:0] get_out(input int d);
    return (d == 0) ? b1.out : b2.out;
  endfunction
  function automatic logic get_ov(input int d);
    return (d == 0) ? b1.out_valid : b2.out_valid;
  endfunction
  function automatic logic get_ir(input int d);
    return (d == 0) ? b1.in_ready : b2.in_ready;
  endfunction
  function automatic logic get_nv(input int d);
    return (d == 0) ? b1.flag_nv : b2.flag_nv;
  endfunction
  function automatic logic get_nx(input int d);
    return (d == 0) ? b1.flag_nx : b2.flag_nx;
  endfunction

  // Reference: exact integer square root of the scaled significand,
  // then round-to-nearest-even from round bit and exactness.
  task automatic model(input logic [31:0] x, output logic [31:0] r,
                       output logic nv, output logic nx, output logic special);
    logic       s;
    logic [7:0] ex;
    logic [22:0] fr;
    longint     m, a, rt, q;
    int         e, sh, eo, bexp;
    logic       rb, st, up;
    s = x[31]; ex = x[30:23]; fr = x[22:0];
    nv = 1'b0; nx = 1'b0; special = 1'b1; r = '0;
    if (ex == 8'hFF && fr != 0) begin
      r = QNAN; nv = !fr[22];
    end else if (ex == 8'h00 && fr == 0) begin
      r = x;
    end else if (s) begin
      r = QNAN; nv = 1'b1;
    end else if (ex == 8'hFF) begin
      r = x;
    end else begin
      special = 1'b0;
      if (ex == 0) begin
        m = longint'(fr); e = -149;
      end else begin
        m = longint'(fr) + (longint'(1) << 23); e = int'(ex) - 150;
      end
      while (m < (longint'(1) << 23)) begin
        m = m * 2; e = e - 1;
      end
      sh = ((e & 1) != 0) ? 25 : 26;
      a  = m << sh;
      rt = longint'($floor($sqrt(real'(a))));
      while (rt * rt > a) rt = rt - 1;
      while ((rt + 1) * (rt + 1) <= a) rt = rt + 1;
      eo = (e - sh) / 2;
      q  = rt >> 1;
      rb = rt[0];
      st = (rt * rt != a);
      up = rb & (st | q[0]);
      q  = q + longint'(up);
      if (q == (longint'(1) << 24)) begin
        q = q >> 1; eo = eo + 1;
      end
      bexp = eo + 24 + 127;
      r  = {1'b0, bexp[7:0], q[22:0]};
      nx = rb | st;
    end
  endtask

  // One full transaction starting and ending at a negedge with DUT idle.
  task automatic run_op(input int d, input logic [31:0] x, input logic [31:0] er,
                        input logic env, input logic enx, input int elat, input string tag);
    int cyc;
    drive(d, 1'b1, x, 1'b0);
    check({tag, "_rdy"}, 32'(get_ir(d)), 32'd1);
    @(posedge clk);
    @(negedge clk);
    drive(d, 1'b0, x, 1'b0);
    cyc = 1;
    while (!get_ov(d) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_lat"}, 32'(cyc), 32'(elat));
    check({tag, "_out"}, get_out(d), er);
    check({tag, "_nv"}, 32'(get_nv(d)), 32'(env));
    check({tag, "_nx"}, 32'(get_nx(d)), 32'(enx));
    drive(d, 1'b0, x, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(d, 1'b0, x, 1'b0);
    check({tag, "_idle"}, 32'(get_ir(d)), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] x, er, rnd;
    logic        env, enx, sp;
    int          cyc, d, cls;

    resetn = 1'b0;
    drive(0, 1'b0, 32'h0, 1'b0);
    drive(1, 1'b0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ov",  32'(get_ov(0)), 32'd0);
    check("rst_out", get_out(0), 32'h0);
    check("rst_nv",  32'(get_nv(0)), 32'd0);
    check("rst_nx",  32'(get_nx(0)), 32'd0);
    check("rst_ir",  32'(get_ir(0)), 32'd0);
    resetn = 1'b1;
    #1;
    check("rst_ir_after", 32'(get_ir(0)), 32'd1);

    run_op(0, 32'h4080_0000, 32'h4000_0000, 1'b0, 1'b0, 28, "exact4");
    run_op(0, 32'h4000_0000, 32'h3FB5_04F3, 1'b0, 1'b1, 28, "two_b1");
    run_op(1, 32'h4000_0000, 32'h3FB5_04F3, 1'b0, 1'b1, 16, "two_b2");
    run_op(0, 32'h0000_0001, 32'h1A35_04F3, 1'b0, 1'b1, 28, "subn");
    run_op(0, 32'hBF80_0000, QNAN,          1'b1, 1'b0, 1,  "neg1");
    run_op(0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1,  "negz");
    run_op(0, 32'h7F80_0000, 32'h7F80_0000, 1'b0, 1'b0, 1,  "pinf");
    run_op(0, 32'h7F80_0001, QNAN,          1'b1, 1'b0, 1,  "snan");
    run_op(1, 32'h4080_0000, 32'h4000_0000, 1'b0, 1'b0, 16, "exact4_b2");

    // backpressure, ignored in_valid while busy, simultaneous in_valid/out_ready
    drive(0, 1'b1, 32'h4080_0000, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 32'h4080_0000, 1'b0);
    cyc = 1;
    while (!get_ov(0) && cyc < 200) begin
      drive(0, (cyc == 5), 32'h4110_0000, 1'b0);
      @(negedge clk);
      cyc++;
    end
    drive(0, 1'b0, 32'h4110_0000, 1'b0);
    check("bp_lat", 32'(cyc), 32'd28);
    for (int i = 0; i < 5; i++) begin
      check("bp_out", get_out(0), 32'h4000_0000);
      check("bp_ov",  32'(get_ov(0)), 32'd1);
      check("bp_ir",  32'(get_ir(0)), 32'd0);
      drive(0, (i == 2), 32'h4110_0000, 1'b0);
      @(posedge clk);
      @(negedge clk);
    end
    drive(0, 1'b1, 32'h4110_0000, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 32'h4110_0000, 1'b0);
    check("bp_consume_ov", 32'(get_ov(0)), 32'd0);
    check("bp_consume_ir", 32'(get_ir(0)), 32'd1);
    run_op(0, 32'h4110_0000, 32'h4040_0000, 1'b0, 1'b0, 28, "bp_second");

    // reset in the middle of CALC
    drive(0, 1'b1, 32'h4000_0000, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 32'h4000_0000, 1'b0);
    repeat (9) @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check("midrst_ov",  32'(get_ov(0)), 32'd0);
    check("midrst_out", get_out(0), 32'h0);
    check("midrst_ir",  32'(get_ir(0)), 32'd1);
    @(negedge clk);
    run_op(0, 32'h4110_0000, 32'h4040_0000, 1'b0, 1'b0, 28, "nine");

    // randomized operands against the reference model
    for (int i = 0; i < 40; i++) begin
      d   = i % 2;
      cls = $urandom_range(0, 9);
      rnd = $urandom;
      if (cls <= 4) begin
        x = {1'b0, 8'($urandom_range(1, 254)), rnd[22:0]};
      end else if (cls <= 6) begin
        x = {1'b0, 8'h00, rnd[22:0]};
        if (x == 32'h0) x = 32'h0000_0003;
      end else if (cls == 7) begin
        x = {1'b1, rnd[30:0]};
      end else if (cls == 8) begin
        x = {rnd[31], 8'hFF, rnd[22:0]};
        if (rnd[22:0] == 23'h0) x[0] = 1'b1;
      end else begin
        x = {rnd[31], rnd[0] ? 8'hFF : 8'h00, 23'h0};
      end
      model(x, er, env, enx, sp);
      run_op(d, x, er, env, enx, sp ? 1 : ((d == 0) ? 28 : 16), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
